nn_config_loader: RTL and testbench
===================================

Name: nn_config_loader

Overview:
- Sequences network configuration into the neuron array.
- Accepts a flat stream of 32-bit configuration words from the host-side interface (valid/ready).
- Emits the per-neuron write strobes that every neuron instance decodes: weightValid/weightValue, biasValid/biasValue, config_layer_num/config_neuron_num.
- Stream order is fixed: layer by layer, neuron by neuron, all weights of a neuron followed by its single bias word.

Parameters:
- numLayers, 3, number of layers to load, 1..4.
- firstLayerNo, 1, value driven on config_layer_num for the first layer.
- neurons0 / neurons1 / neurons2 / neurons3, 30/30/10/10, neurons in layer 0..3; entries at or above numLayers are unused.
- weights0 / weights1 / weights2 / weights3, 784/30/30/10, weights per neuron in layer 0..3 (equals that layer's numWeight).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse that begins a load sequence
- cfg_data  in  32  configuration word
- cfg_valid  in  1  cfg_data valid
- cfg_ready  out  1  loader accepts a word this cycle
- weightValid  out  1  weight write strobe
- weightValue  out  16  weight word, equal to cfg_data[15:0]
- biasValid  out  1  bias write strobe
- biasValue  out  32  bias word, equal to cfg_data
- config_layer_num  out  32  target layer for the current strobe
- config_neuron_num  out  32  target neuron for the current strobe
- busy  out  1  load in progress
- done  out  1  full configuration delivered

Behaviour:
- Reset values (asynchronous): all outputs 0, state IDLE, layer/neuron/weight counters 0.
- FSM states: IDLE, WEIGHT, BIAS, DONE.
- IDLE or DONE + start=1 → WEIGHT. On entry:
  - layer=0, neuron=0, wcnt=0.
  - done cleared, busy set.
- start while in WEIGHT or BIAS: ignored.
- cfg_ready = 1 exactly in WEIGHT and BIAS; 0 in IDLE and DONE. It is a registered-state decode, not dependent on cfg_valid.
- A word is accepted on a clk edge where cfg_valid & cfg_ready. No other word has any effect; the loader never drops an accepted word.
- Throughput: one word per cycle sustained.
- Latency is 1 cycle, with all strobe outputs registered:
  - A word accepted at edge N in WEIGHT → weightValid=1 during the cycle after edge N, weightValue=cfg_data[15:0].
  - A word accepted at edge N in BIAS → biasValid=1 during the cycle after edge N, biasValue=cfg_data.
  - config_layer_num and config_neuron_num update on the same edge as the strobe, so they are valid and stable throughout the strobe cycle.
  - Strobes are single-cycle per word; weightValid and biasValid are never both 1.
- config_layer_num = layer + firstLayerNo. config_neuron_num = neuron, 0-based. Both hold their last value between strobes.
- WEIGHT transitions:
  - On each accept, wcnt increments.
  - When the accepted word is the last weight (wcnt == weightsL-1) → BIAS, with wcnt reset to 0.
  - weightsL and neuronsL are selected from the parameters by layer.
- BIAS transitions, on accept:
  - If neuron < neuronsL-1: neuron+1 → WEIGHT.
  - Else if layer < numLayers-1: layer+1, neuron=0 → WEIGHT.
  - Else → DONE.
- DONE: busy=0, done=1; done holds until the next start or rst.
- busy=1 in WEIGHT and BIAS; it falls on the edge that enters DONE, together with the final biasValid.
- Gaps: cfg_valid low for any number of cycles stalls the sequence with no strobe and no state change.
- Counter widths:
  - wcnt is wide enough for the largest weightsX.
  - neuron and layer counters are 8 bits, zero-extended to 32 bits on output.
- Reset mid-operation: return to IDLE immediately and drop any pending strobe. The system reset also clears each neuron's weight write address, so a new start reloads from the first word.

Test Plan:
- Config numLayers=2, neurons0=2, weights0=3, neurons1=1, weights1=2; start, then 11 back-to-back words 1..11. Required strobe sequence:
  - layer 1, neuron 0: weightValid for words 1, 2, 3; biasValid for word 4.
  - layer 1, neuron 1: weightValid for words 5, 6, 7; biasValid for word 8.
  - layer 2, neuron 0: weightValid for words 9, 10; biasValid for word 11.
  - Each strobe lands exactly 1 cycle after its accept; done=1 on the cycle after the last accept.
- Same stream with cfg_valid toggled 1,0,0,1,... → identical strobe/value sequence, with stalls only; no strobe while cfg_valid=0.
- Word 0xABCD1234 accepted in WEIGHT → weightValue=0x1234. Word 0xFFFF8000 in BIAS → biasValue=0xFFFF8000.
- start pulsed in the middle of layer 1 → ignored, sequence unchanged. Second start after DONE → done=0, busy=1, config_layer_num starts at 1 again.
- rst asserted asynchronously after word 6 → all outputs 0 and cfg_ready=0 without waiting for a clk edge. After a new start, the first accepted word targets layer 1, neuron 0.
- cfg_valid=1 while in IDLE/DONE → cfg_ready=0 and no strobes.

Source files
------------

// File: rtl/nn_config_loader.sv
// nn_config_loader
// Takes a flat stream of 32-bit configuration words (valid/ready) and turns it
// into the per-neuron write strobes decoded by every neuron instance. The stream
// is ordered layer by layer and neuron by neuron. Each neuron gets all of its
// weight words and then one bias word.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   start               one-cycle pulse that begins a load (ignored while loading)
//   cfg_data/cfg_valid  incoming configuration word
//   cfg_ready           high while loading (WEIGHT or BIAS); a pure state decode
//   weightValid/Value   weight write strobe, value = cfg_data[15:0]
//   biasValid/Value     bias write strobe, value = cfg_data
//   config_layer_num    target layer of the current strobe (layer + firstLayerNo)
//   config_neuron_num   target neuron of the current strobe (0-based)
//   busy / done         load in progress / full configuration delivered
module nn_config_loader #(
  parameter int numLayers    = 3,
  parameter int firstLayerNo = 1,
  parameter int neurons0     = 30,
  parameter int neurons1     = 30,
  parameter int neurons2     = 10,
  parameter int neurons3     = 10,
  parameter int weights0     = 784,
  parameter int weights1     = 30,
  parameter int weights2     = 30,
  parameter int weights3     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] cfg_data,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  output logic        weightValid,
  output logic [15:0] weightValue,
  output logic        biasValid,
  output logic [31:0] biasValue,
  output logic [31:0] config_layer_num,
  output logic [31:0] config_neuron_num,
  output logic        busy,
  output logic        done
);

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // The weight counter covers every layer's weight count, including layers that
  // are not in use, so a parameter change never silently truncates it.
  localparam int MAXW = max4(weights0, weights1, weights2, weights3);
  localparam int WCW  = $clog2(MAXW + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WEIGHT = 2'd1,
    BIAS   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       layer_q, layer_d;
  logic [7:0]       neuron_q, neuron_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;

  logic             wv_q, wv_d;
  logic [15:0]      wval_q, wval_d;
  logic             bv_q, bv_d;
  logic [31:0]      bval_q, bval_d;
  logic [31:0]      lnum_q, lnum_d;
  logic [31:0]      nnum_q, nnum_d;

  logic             accept;
  logic [31:0]      weights_l;
  logic [31:0]      neurons_l;

  function automatic logic [31:0] weights_of(input logic [7:0] l);
    case (l)
      8'd0:    return 32'(weights0);
      8'd1:    return 32'(weights1);
      8'd2:    return 32'(weights2);
      default: return 32'(weights3);
    endcase
  endfunction

  function automatic logic [31:0] neurons_of(input logic [7:0] l);
    case (l)
      8'd0:    return 32'(neurons0);
      8'd1:    return 32'(neurons1);
      8'd2:    return 32'(neurons2);
      default: return 32'(neurons3);
    endcase
  endfunction

  assign weights_l = weights_of(layer_q);
  assign neurons_l = neurons_of(layer_q);

  // Ready comes from the registered state only. It never looks at cfg_valid,
  // so there is no combinational path from valid to ready.
  assign cfg_ready = (state_q == WEIGHT) || (state_q == BIAS);
  assign accept    = cfg_valid && cfg_ready;

  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    neuron_d = neuron_q;
    wcnt_d   = wcnt_q;
    wv_d     = 1'b0;
    bv_d     = 1'b0;
    wval_d   = wval_q;
    bval_d   = bval_q;
    lnum_d   = lnum_q;
    nnum_d   = nnum_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = WEIGHT;
          layer_d  = 8'd0;
          neuron_d = 8'd0;
          wcnt_d   = '0;
        end
      end

      WEIGHT: begin
        if (accept) begin
          wv_d   = 1'b1;
          wval_d = cfg_data[15:0];
          lnum_d = 32'(layer_q) + 32'(firstLayerNo);
          nnum_d = 32'(neuron_q);
          if (32'(wcnt_q) == weights_l - 32'd1) begin
            wcnt_d  = '0;
            state_d = BIAS;
          end else begin
            wcnt_d = wcnt_q + {{(WCW-1){1'b0}}, 1'b1};
          end
        end
      end

      BIAS: begin
        if (accept) begin
          bv_d   = 1'b1;
          bval_d = cfg_data;
          lnum_d = 32'(layer_q) + 32'(firstLayerNo);
          nnum_d = 32'(neuron_q);
          if (32'(neuron_q) < neurons_l - 32'd1) begin
            neuron_d = neuron_q + 8'd1;
            state_d  = WEIGHT;
          end else if (32'(layer_q) < 32'(numLayers) - 32'd1) begin
            layer_d  = layer_q + 8'd1;
            neuron_d = 8'd0;
            state_d  = WEIGHT;
          end else begin
            state_d = DONE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      layer_q  <= 8'd0;
      neuron_q <= 8'd0;
      wcnt_q   <= '0;
      wv_q     <= 1'b0;
      wval_q   <= 16'd0;
      bv_q     <= 1'b0;
      bval_q   <= 32'd0;
      lnum_q   <= 32'd0;
      nnum_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      neuron_q <= neuron_d;
      wcnt_q   <= wcnt_d;
      wv_q     <= wv_d;
      wval_q   <= wval_d;
      bv_q     <= bv_d;
      bval_q   <= bval_d;
      lnum_q   <= lnum_d;
      nnum_q   <= nnum_d;
    end
  end

  assign weightValid       = wv_q;
  assign weightValue       = wval_q;
  assign biasValid         = bv_q;
  assign biasValue         = bval_q;
  assign config_layer_num  = lnum_q;
  assign config_neuron_num = nnum_q;
  // busy drops on the edge that enters DONE, in the same cycle as the last biasValid.
  assign busy              = cfg_ready;
  assign done              = (state_q == DONE);

endmodule

// File: tb/tb_nn_config_loader.sv
module tb_nn_config_loader;
  localparam int NL = 2, FL = 1, N0 = 2, W0 = 3, N1 = 1, W1 = 2;
  localparam int NSLOT = N0 * (W0 + 1) + N1 * (W1 + 1);

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, cfg_valid = 1'b0;
  logic [31:0] cfg_data = 32'd0;
  logic        cfg_ready, weightValid, biasValid, busy, done;
  logic [15:0] weightValue;
  logic [31:0] biasValue, config_layer_num, config_neuron_num;

  nn_config_loader #(
    .numLayers(NL), .firstLayerNo(FL),
    .neurons0(N0), .neurons1(N1), .neurons2(5), .neurons3(5),
    .weights0(W0), .weights1(W1), .weights2(7), .weights3(7)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .weightValid(weightValid), .weightValue(weightValue),
    .biasValid(biasValid), .biasValue(biasValue), .config_layer_num(config_layer_num),
    .config_neuron_num(config_neuron_num), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  // Slot table: for each word position in the stream, whether it is a bias word
  // and which layer/neuron it belongs to.
  bit sb[NSLOT];
  int sl[NSLOT], sn[NSLOT];

  // Reference model: the loader is a cursor that walks the slot table.
  bit          m_run, m_done, m_wv, m_bv;
  logic [15:0] m_wval;
  logic [31:0] m_bval, m_l, m_n;
  int          m_ptr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 0; m_done <= 0; m_wv <= 0; m_bv <= 0;
      m_l <= 0; m_n <= 0; m_ptr <= 0;
    end else begin
      m_wv <= 0; m_bv <= 0;
      if (m_run) begin
        if (cfg_valid) begin
          if (sb[m_ptr]) begin m_bv <= 1; m_bval <= cfg_data; end
          else begin m_wv <= 1; m_wval <= cfg_data[15:0]; end
          m_l   <= 32'(sl[m_ptr] + FL);
          m_n   <= 32'(sn[m_ptr]);
          m_ptr <= m_ptr + 1;
          if (m_ptr == NSLOT - 1) begin m_run <= 0; m_done <= 1; end
        end
      end else if (start) begin
        m_run <= 1; m_ptr <= 0; m_done <= 0;
      end
    end
  end

  typedef struct { bit b; logic [31:0] v; logic [31:0] l; logic [31:0] n; } ent_t;
  ent_t log_q[$];

  always @(negedge clk) begin
    chk("cfg_ready", cfg_ready, m_run);
    chk("busy", busy, m_run);
    chk("done", done, m_done);
    chk("weightValid", weightValid, m_wv);
    chk("biasValid", biasValid, m_bv);
    chk("layer_num", config_layer_num, m_l);
    chk("neuron_num", config_neuron_num, m_n);
    if (m_wv) chk("weightValue", weightValue, m_wval);
    if (m_bv) chk("biasValue", biasValue, m_bval);
    if (weightValid) log_q.push_back('{1'b0, 32'(weightValue), config_layer_num, config_neuron_num});
    if (biasValid)   log_q.push_back('{1'b1, biasValue, config_layer_num, config_neuron_num});
  end

  logic [31:0] words[NSLOT];

  task automatic pulse_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  // mode 0: back-to-back, 1: valid pattern 1,0,0,..., 2: random valid.
  // start is re-pulsed alongside word index start_at (-1 = never).
  task automatic drive_words(input int n, input int mode, input int start_at);
    int i = 0, cyc = 0;
    bit v;
    while (i < n && cyc < 2000) begin
      @(negedge clk);
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      cfg_valid = v;
      cfg_data  = v ? words[i] : $urandom;
      start     = (v && i == start_at);
      if (v) i++;
      cyc++;
    end
    if (i < n) chk("drive_timeout", 32'(i), 32'(n));
  endtask

  task automatic finish_stream();
    @(negedge clk); cfg_valid = 0; start = 0;
    repeat (2) @(negedge clk);
  endtask

  // Literal expectations for the slot sequence under the bench configuration.
  int eb[11] = '{0,0,0,1,0,0,0,1,0,0,1};
  int el[11] = '{1,1,1,1,1,1,1,1,2,2,2};
  int en[11] = '{0,0,0,0,1,1,1,1,0,0,0};

  task automatic check_seq(input bit vals);
    chk("seq_len", 32'(log_q.size()), 32'd11);
    for (int k = 0; k < 11; k++) begin
      if (k < log_q.size()) begin
        chk("seq_type", 32'(log_q[k].b), 32'(eb[k]));
        chk("seq_layer", log_q[k].l, 32'(el[k]));
        chk("seq_neuron", log_q[k].n, 32'(en[k]));
        if (vals) chk("seq_val", log_q[k].v, 32'(k + 1));
      end
    end
  endtask

  initial begin
    int k = 0;
    for (int l = 0; l < NL; l++) begin
      int nl, wl;
      nl = (l == 0) ? N0 : N1;
      wl = (l == 0) ? W0 : W1;
      for (int n = 0; n < nl; n++) begin
        for (int w = 0; w < wl; w++) begin sb[k] = 0; sl[k] = l; sn[k] = n; k++; end
        sb[k] = 1; sl[k] = l; sn[k] = n; k++;
      end
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wval", weightValue, 0);
    chk("rst_bval", biasValue, 0);
    rst = 0;

    // Valid while idle is not consumed
    repeat (4) begin @(negedge clk); cfg_valid = 1; cfg_data = $urandom; end
    chk("idle_ready", cfg_ready, 0);
    @(negedge clk); cfg_valid = 0;

    // Back-to-back words 1..11
    for (int i = 0; i < NSLOT; i++) words[i] = 32'(i + 1);
    pulse_start(); log_q.delete();
    drive_words(NSLOT, 0, -1);
    @(negedge clk); cfg_valid = 0;
    chk("b2b_done", done, 1);
    chk("b2b_busy", busy, 0);
    repeat (2) @(negedge clk);
    check_seq(1);

    // Valid while done is not consumed
    repeat (4) begin @(negedge clk); cfg_valid = 1; cfg_data = $urandom; end
    chk("done_ready", cfg_ready, 0);
    @(negedge clk); cfg_valid = 0;

    // Restart from DONE with a gapped stream
    pulse_start();
    chk("restart_done", done, 0);
    chk("restart_busy", busy, 1);
    log_q.delete();
    drive_words(NSLOT, 1, -1);
    finish_stream();
    check_seq(1);

    // Word value extraction and an ignored start in the middle of layer 1
    for (int i = 0; i < NSLOT; i++) words[i] = $urandom;
    words[0] = 32'hABCD1234;
    words[3] = 32'hFFFF8000;
    pulse_start(); log_q.delete();
    drive_words(NSLOT, 0, 4);
    finish_stream();
    check_seq(0);
    if (log_q.size() > 3) begin
      chk("wval_lit", log_q[0].v, 32'h0000_1234);
      chk("bval_lit", log_q[3].v, 32'hFFFF_8000);
    end

    // Asynchronous reset after word 6
    for (int i = 0; i < NSLOT; i++) words[i] = 32'(i + 1);
    pulse_start();
    drive_words(6, 0, -1);
    @(posedge clk); #2; rst = 1; #1;
    chk("arst_wv", weightValid, 0);
    chk("arst_bv", biasValid, 0);
    chk("arst_ready", cfg_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_layer", config_layer_num, 0);
    chk("arst_neuron", config_neuron_num, 0);
    chk("arst_wval", weightValue, 0);
    @(negedge clk); cfg_valid = 0; rst = 0;
    pulse_start(); log_q.delete();
    drive_words(NSLOT, 2, -1);
    finish_stream();
    check_seq(1);

    // Randomized runs
    repeat (4) begin
      for (int i = 0; i < NSLOT; i++) words[i] = $urandom;
      pulse_start(); log_q.delete();
      drive_words(NSLOT, 2, int'($urandom_range(0, NSLOT - 1)));
      finish_stream();
      check_seq(0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
